// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with registered one-hot grant; RR_ARBITER4_HOLD_LIMIT_EN adds MAX_HOLD forced rotation
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, idx_n, k;
  logic [3:0] grant_n;
  logic [2:0] hit, rel;
  logic vld_n;
  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter4: illegal MAX_HOLD/CNT_W");
  end
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] s);
    logic [2:0] p;
    p = '0;
    for (int i = 3; i >= 0; i--)
      if (r[s + 2'(i)]) p = {1'b1, s + 2'(i)};
    return p;
  endfunction
  assign k = grant_idx;
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic [2:0] oth;
  always_ff @(posedge clk or posedge reset)
    if (reset) hold_cnt <= '0;
    else hold_cnt <= hold_n;
`endif
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    idx_n = grant_idx;
    vld_n = 1'b0;
    hit = pick(req, ptr);
    rel = pick(req, k + 2'd1);
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
    hold_n = '0;
    oth = pick(req & ~(4'b0001 << k), k + 2'd1);
`endif
    if (state == IDLE) begin
      if (enable && hit[2]) begin
        state_n = BUSY;
        idx_n = hit[1:0];
        vld_n = 1'b1;
      end
    end else if (!enable) begin
      state_n = IDLE;
    end else if (!req[k]) begin
      ptr_n = k + 2'd1;
      vld_n = rel[2];
      idx_n = rel[2] ? rel[1:0] : k;
      state_n = rel[2] ? BUSY : IDLE;
    end
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
    else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
      ptr_n = k + 2'd1;
      vld_n = 1'b1;
      idx_n = oth[2] ? oth[1:0] : k;
    end else begin
      vld_n = 1'b1;
      hold_n = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
    end
`else
    else vld_n = 1'b1;
`endif
    grant_n = vld_n ? 4'b0001 << idx_n : 4'b0000;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      grant_idx <= '0;
      grant_valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant <= grant_n;
      grant_idx <= idx_n;
      grant_valid <= vld_n;
    end
endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter sharing one resource between four requesters.
- Produces a registered one-hot grant plus its 2-bit encoded index.
- The one-hot output has the same encoding as the team's 2-to-4 binary decoder: index 0 maps to 4'b0001, index 3 maps to 4'b1000, and all zeros when not enabled.
- Sits in front of any shared datapath stage; downstream muxes select on grant_idx.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold the grant before forced rotation. Legal range 1..255; only used when the optional feature is compiled in.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  arbiter enable. Low forces the grant off.
- req  input  4  request vector; bit i belongs to requester i.
- grant  output  4  registered one-hot grant, or 4'b0000 when none.
- grant_idx  output  2  encoded index of the current or last grantee.
- grant_valid  output  1  high when grant is non-zero.

Behaviour:
- Reset (async, takes effect immediately): grant=4'b0000, grant_idx=2'b00, grant_valid=0, state=IDLE, ptr=2'b00, hold_cnt=0.
- All outputs are registered. grant, grant_idx and grant_valid always change together on the same edge.
- ptr: 2-bit round-robin start position. Priority search order is ptr, ptr+1, ptr+2, ptr+3, mod 4 (wraps 3 to 0).
- State IDLE:
  - If enable=1 and req!=0 at an edge: grant the first requester in search order from ptr; go to BUSY; hold_cnt=0.
  - Latency: request sampled at edge N, grant visible after edge N (1 cycle).
  - Otherwise outputs stay at grant=0, grant_valid=0; grant_idx keeps its last value.
- State BUSY (current grantee k), evaluated each edge in this priority order:
  - enable=0: grant=0, valid=0, go to IDLE; ptr unchanged; hold_cnt=0.
  - req[k]=0 (release): ptr=k+1. If any other req bit is set, grant the next winner searching from k+1, with no idle bubble (stay in BUSY, hold_cnt=0). Otherwise grant=0 and go to IDLE.
  - Hold limit reached (optional feature only; hold_cnt==MAX_HOLD-1): ptr=k+1. Grant the next other requester from k+1 if one exists. If k is the only requester, re-grant k with hold_cnt=0.
  - Otherwise: keep the grant; hold_cnt=hold_cnt+1, saturating at its maximum.
- Requests are level-sensitive. A requester must hold req high for as long as it uses the resource. No other handshake.
- Simultaneous release by k and new requests: handled as a release. The new winner is searched from k+1 on the same edge.
- Fairness: a requester that is continuously requesting waits at most 3 grant tenures.
- grant is never multi-hot. grant_valid == |grant at all times.
- Reset asserted mid-tenure: grant drops asynchronously; the next arbitration starts from ptr=0.

Optional Feature:
- Macro: RR_ARBITER4_HOLD_LIMIT_EN.
- Defined: hold_cnt is implemented and the MAX_HOLD forced rotation rule applies.
- Undefined: no hold counter logic. A grantee keeps the grant indefinitely while its req stays high and enable=1. MAX_HOLD and CNT_W are ignored.
- Port list is identical in both builds.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, req=4'b1111, enable=1; release reset -> grant=4'b0000 during reset; after first edge, grant=4'b0001, grant_idx=0, grant_valid=1.
- Rotation: req=4'b1111 held; each grantee drops its req for 1 cycle then re-raises -> grant sequence 0001, 0010, 0100, 1000, 0001 (wrap).
- Back-to-back handoff: grantee 1 active, req=4'b1010; drop req[1] -> the next edge gives grant=4'b1000, with no cycle of grant=0.
- Enable low: in BUSY with grant=4'b0100, enable=0 -> next edge grant=0, valid=0; enable=1 with req=4'b0100 -> grant=4'b1000 not available, so re-grant 0100 (ptr was unchanged at 2).
- Hold limit (macro defined, MAX_HOLD=4): req=4'b0011 held constant -> requester 0 granted for 4 cycles, then 1 for 4 cycles, then 0 again. With req=4'b0001 only, grant stays 0001 continuously. Same stimulus with macro undefined -> requester 0 never loses the grant.
- Async reset mid-tenure: assert reset between clock edges while grant=4'b1000 -> grant=0 immediately, without waiting for a clock edge; after release, arbitration restarts from index 0.
